// File: rtl/wb_host_pkg.sv
// Purpose: shared constants and FSM state type for the Wishbone host master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_host_pkg;

  localparam int WB_ADR_W       = 16;
  localparam int WB_DAT_W       = 8;
  localparam int WB_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } wb_state_e;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int ctr_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_host_master_if.sv
// Purpose: groups the command, response and Wishbone signals of the host master.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/ready and rsp_valid/ready handshakes; Wishbone cyc/ack.
// Ports: master modport is the wb_host_master view (suffix _i = into the master,
//        _o = out of it); slave modport is the mirror seen by host and register file.
interface wb_host_master_if #(
  parameter int ADR_W = 16,
  parameter int DAT_W = 8
);
  // command stream
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_we_i;
  logic [ADR_W-1:0] cmd_adr_i;
  logic [DAT_W-1:0] cmd_dat_i;
  // response stream
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [DAT_W-1:0] rsp_dat_o;
  logic             rsp_err_o;
  // Wishbone classic bus
  logic             cyc_o;
  logic             stb_o;
  logic [ADR_W-1:0] adr_o;
  logic             we_o;
  logic             sel_o;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;
  logic             ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, dat_i, ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output cyc_o, stb_o, adr_o, we_o, sel_o, dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, dat_i, ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  cyc_o, stb_o, adr_o, we_o, sel_o, dat_o
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Purpose: saturating cycle counter that flags the last allowed bus cycle.
// Latency: count updates one edge after i_en; o_expired is a decode of the count.
// Backpressure: none; i_clr has priority over i_en.
// Ports: clk_i/rst_i clock and sync reset, i_clr zero the count, i_en count one
//        cycle, o_expired high while the count is at TIMEOUT-1 or above.
module wb_timeout_ctr
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int            CW     = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The count holds the number of un-acked cycles already completed, so the
  // cycle seen with TIMEOUT-1 is the TIMEOUT-th and final one.
  assign o_expired = (r_cnt >= C_LAST);

endmodule

// File: rtl/wb_host_master.sv
// Purpose: turns each command into one single-beat Wishbone classic read/write and one response.
// Latency: cyc_o one cycle after accept; response one cycle after ack, or after TIMEOUT bus cycles.
// Backpressure: cmd_ready_o low from accept until the response is taken; response held until rsp_ready_i.
// Ports: clk_i clock, rst_i sync active-high reset, wb master modport carrying the
//        command stream, response stream and Wishbone initiator signals.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_host_master_if.master    wb
);

  wb_state_e        r_state, w_state;
  logic             r_cmd_ready, w_cmd_ready;
  logic             r_cyc, w_cyc;
  logic             r_we, w_we;
  logic [ADR_W-1:0] r_adr, w_adr;
  logic [DAT_W-1:0] r_dat, w_dat;
  logic             r_rsp_valid, w_rsp_valid;
  logic             r_rsp_err, w_rsp_err;
  logic [DAT_W-1:0] r_rsp_dat, w_rsp_dat;
  logic             w_ctr_clr, w_ctr_en, w_expired;

  wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clr    (w_ctr_clr),
    .i_en     (w_ctr_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_cyc       <= w_cyc;
      r_we        <= w_we;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_dat   <= w_rsp_dat;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cmd_ready = r_cmd_ready;
    w_cyc       = r_cyc;
    w_we        = r_we;
    w_adr       = r_adr;
    w_dat       = r_dat;
    w_rsp_valid = r_rsp_valid;
    w_rsp_err   = r_rsp_err;
    w_rsp_dat   = r_rsp_dat;
    w_ctr_clr   = 1'b0;
    w_ctr_en    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (wb.cmd_valid_i && r_cmd_ready) begin
          w_state     = BUS;
          w_cmd_ready = 1'b0;
          w_cyc       = 1'b1;
          w_we        = wb.cmd_we_i;
          w_adr       = wb.cmd_adr_i;
          w_dat       = wb.cmd_dat_i;
          w_ctr_clr   = 1'b1;
        end
      end
      BUS: begin
        // Ack is tested first so an ack in the final allowed cycle still succeeds.
        if (wb.ack_i) begin
          w_state     = RSP;
          w_cyc       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b0;
          w_rsp_dat   = r_we ? '0 : wb.dat_i;
        end else if (w_expired) begin
          w_state     = RSP;
          w_cyc       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_dat   = '0;
        end else begin
          w_ctr_en = 1'b1;
        end
      end
      RSP: begin
        // ack_i is deliberately not looked at here: a late ack must not matter.
        if (wb.rsp_ready_i) begin
          w_state     = IDLE;
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign wb.cmd_ready_o = r_cmd_ready;
  assign wb.cyc_o       = r_cyc;
  assign wb.stb_o       = r_cyc;
  assign wb.sel_o       = r_cyc;
  assign wb.we_o        = r_we;
  assign wb.adr_o       = r_adr;
  assign wb.dat_o       = r_dat;
  assign wb.rsp_valid_o = r_rsp_valid;
  assign wb.rsp_err_o   = r_rsp_err;
  assign wb.rsp_dat_o   = r_rsp_dat;

endmodule

// File: tb/tb_wb_host_master.sv
// Purpose: self-checking bench for wb_host_master against a register-file slave model.
// Latency: expectations are 2 + slave wait states, or TIMEOUT+1 on timeout.
// Backpressure: bench varies rsp_ready_i delay and holds cmd_valid_i during stalls.
`timescale 1ns/1ps
module tb_wb_host_master;
  import wb_host_pkg::*;

  localparam int TO   = 4;
  localparam int MAXW = 200;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wb_host_master_if #(.ADR_W(WB_ADR_W), .DAT_W(WB_DAT_W)) wb();

  wb_host_master #(.ADR_W(WB_ADR_W), .DAT_W(WB_DAT_W), .TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wb   (wb.master)
  );

  // ---------------- register-file slave: ack after ack_wait cycles, -1 = never
  logic [7:0] slv_mem [0:255];
  int         ack_wait = 0;
  int         wait_cnt = 0;
  logic       late_ack = 1'b0;

  assign wb.ack_i = late_ack | (wb.cyc_o && (ack_wait >= 0) && (wait_cnt >= ack_wait));
  assign wb.dat_i = (wb.cyc_o && !wb.we_o) ? slv_mem[wb.adr_o[7:0]] : 8'h00;

  always @(posedge clk) begin
    if (wb.cyc_o && !wb.ack_i) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
    if (wb.cyc_o && wb.stb_o && wb.ack_i && wb.we_o) slv_mem[wb.adr_o[7:0]] <= wb.dat_o;
  end

  // ---------------- bus monitor: one record per cyc_o burst, plus handshake cycles
  typedef struct {
    logic [15:0] adr;
    logic        we;
    logic [7:0]  dat;
    int          len;
    logic        acked;
  } burst_t;

  burst_t bq[$];
  burst_t cur;
  int     hs_q[$];
  int     cyc_no = 0;
  int     viol = 0;
  logic   prev_cyc = 1'b0;
  logic   prev2_cyc = 1'b0;

  always @(negedge clk) begin
    #1;
    cyc_no++;
    if (wb.cyc_o === 1'b1) begin
      if (prev_cyc !== 1'b1) begin
        if (prev2_cyc === 1'b1) viol++;
        cur.adr = wb.adr_o; cur.we = wb.we_o; cur.dat = wb.dat_o; cur.len = 0;
      end else if (wb.adr_o !== cur.adr || wb.we_o !== cur.we || wb.dat_o !== cur.dat) begin
        viol++;
      end
      cur.len++;
      cur.acked = wb.ack_i;
    end else if (prev_cyc === 1'b1) begin
      bq.push_back(cur);
    end
    if (wb.stb_o !== wb.cyc_o || wb.sel_o !== wb.cyc_o) viol++;
    if (wb.cmd_valid_i === 1'b1 && wb.cmd_ready_o === 1'b1) hs_q.push_back(cyc_no);
    prev2_cyc = prev_cyc;
    prev_cyc  = wb.cyc_o;
  end

  // ---------------- reference model: memory contents as seen by commands
  logic [7:0] ref_mem [logic [15:0]];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // ---------------- one full command/response exchange
  task automatic do_cmd(input logic we, input logic [15:0] adr, input logic [7:0] dat,
                        input int rdy_delay, input logic late,
                        output logic [7:0] rdat, output logic err, output int lat, output logic held);
    int n;
    @(negedge clk);
    wb.cmd_valid_i = 1'b1; wb.cmd_we_i = we; wb.cmd_adr_i = adr; wb.cmd_dat_i = dat;
    n = 0;
    while (wb.cmd_ready_o !== 1'b1 && n < MAXW) begin @(negedge clk); n++; end
    if (n >= MAXW) begin tests++; fails++; $display("FAIL cmd_accept: cmd_ready_o never rose within %0d cycles", MAXW); end
    @(negedge clk);
    wb.cmd_valid_i = 1'b0; wb.cmd_we_i = 1'b0; wb.cmd_adr_i = '0; wb.cmd_dat_i = '0;
    lat = 1;
    while (wb.rsp_valid_o !== 1'b1 && lat < MAXW) begin @(negedge clk); lat++; end
    if (lat >= MAXW) begin tests++; fails++; $display("FAIL rsp_wait: no response within %0d cycles", MAXW); end
    rdat = wb.rsp_dat_o;
    err  = wb.rsp_err_o;
    held = 1'b1;
    for (int i = 0; i < rdy_delay; i++) begin
      if (late && i == 0) late_ack = 1'b1;
      @(negedge clk);
      late_ack = 1'b0;
      if (wb.rsp_valid_o !== 1'b1 || wb.rsp_dat_o !== rdat || wb.rsp_err_o !== err || wb.cyc_o !== 1'b0) held = 1'b0;
    end
    wb.rsp_ready_i = 1'b1;
    @(negedge clk);
    wb.rsp_ready_i = 1'b0;
  endtask

  function automatic burst_t pop_burst();
    burst_t b;
    b = '{adr: 16'hxxxx, we: 1'bx, dat: 8'hxx, len: -1, acked: 1'bx};
    if (bq.size() > 0) b = bq.pop_front();
    return b;
  endfunction

  // ---------------- scenarios
  task automatic test_reset();
    wb.cmd_valid_i = 1'b0; wb.cmd_we_i = 1'b0; wb.cmd_adr_i = '0; wb.cmd_dat_i = '0;
    wb.rsp_ready_i = 1'b0; ack_wait = 0; late_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({wb.cmd_ready_o, wb.rsp_valid_o, wb.rsp_err_o} !== 3'b100) begin fails++; $display("FAIL reset_hs: ready/rvalid/err=%b want 100", {wb.cmd_ready_o, wb.rsp_valid_o, wb.rsp_err_o}); end
    tests++; if ({wb.cyc_o, wb.stb_o, wb.sel_o, wb.we_o} !== 4'b0000) begin fails++; $display("FAIL reset_bus: cyc/stb/sel/we=%b want 0000", {wb.cyc_o, wb.stb_o, wb.sel_o, wb.we_o}); end
    tests++; if ({wb.adr_o, wb.dat_o, wb.rsp_dat_o} !== 32'h0) begin fails++; $display("FAIL reset_data: adr/dat/rsp_dat=%h want 0", {wb.adr_o, wb.dat_o, wb.rsp_dat_o}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bq.delete();
  endtask

  task automatic test_write();
    logic [7:0] rd; logic er, hd; int lat; burst_t b;
    ack_wait = 0;
    do_cmd(1'b1, 16'h0012, 8'hA5, 0, 1'b0, rd, er, lat, hd);
    ref_mem[16'h0012] = 8'hA5;
    b = pop_burst();
    tests++; if ({er, rd} !== 9'h000) begin fails++; $display("FAIL write_rsp: err=%b dat=%h want 0/00", er, rd); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL write_latency: %0d want 2", lat); end
    tests++; if (b.adr !== 16'h0012 || b.we !== 1'b1 || b.dat !== 8'hA5 || b.len !== 1) begin fails++; $display("FAIL write_bus: adr=%h we=%b dat=%h len=%0d want 0012/1/a5/1", b.adr, b.we, b.dat, b.len); end
    tests++; if (wb.cmd_ready_o !== 1'b1) begin fails++; $display("FAIL write_ready_after: cmd_ready_o=%b want 1", wb.cmd_ready_o); end
  endtask

  task automatic test_read_registered();
    logic [7:0] rd; logic er, hd; int lat; burst_t b;
    ack_wait = 1;
    do_cmd(1'b0, 16'h0012, 8'h5A, 0, 1'b0, rd, er, lat, hd);
    b = pop_burst();
    tests++; if ({er, rd} !== {1'b0, ref_rd(16'h0012)}) begin fails++; $display("FAIL read_rsp: err=%b dat=%h want 0/%h", er, rd, ref_rd(16'h0012)); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL read_latency: %0d want 3", lat); end
    tests++; if (b.we !== 1'b0 || b.len !== 2 || b.acked !== 1'b1) begin fails++; $display("FAIL read_bus: we=%b len=%0d acked=%b want 0/2/1", b.we, b.len, b.acked); end
  endtask

  task automatic test_timeout();
    logic [7:0] rd; logic er, hd; int lat; burst_t b; int bad;
    ack_wait = -1;
    do_cmd(1'b0, 16'h0033, 8'h00, 3, 1'b1, rd, er, lat, hd);
    b = pop_burst();
    tests++; if ({er, rd} !== 9'h100) begin fails++; $display("FAIL timeout_rsp: err=%b dat=%h want 1/00", er, rd); end
    tests++; if (lat !== TO + 1) begin fails++; $display("FAIL timeout_latency: %0d want %0d", lat, TO + 1); end
    tests++; if (b.len !== TO || b.acked !== 1'b0) begin fails++; $display("FAIL timeout_cyc_len: %0d acked=%b want %0d/0", b.len, b.acked, TO); end
    tests++; if (hd !== 1'b1) begin fails++; $display("FAIL timeout_late_ack_rsp: response changed after late ack"); end
    // a stray ack while idle must not start anything either
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (wb.cyc_o !== 1'b0 || wb.rsp_valid_o !== 1'b0 || wb.cmd_ready_o !== 1'b1) bad++;
    end
    tests++; if (bad !== 0 || bq.size() !== 0) begin fails++; $display("FAIL idle_late_ack: %0d bad cycles, %0d bursts want 0/0", bad, bq.size()); end
  endtask

  task automatic test_ack_at_timeout();
    logic [7:0] rd; logic er, hd; int lat; burst_t b;
    ack_wait = TO - 1;
    do_cmd(1'b0, 16'h0012, 8'h00, 0, 1'b0, rd, er, lat, hd);
    b = pop_burst();
    tests++; if ({er, rd} !== {1'b0, ref_rd(16'h0012)}) begin fails++; $display("FAIL ack_wins: err=%b dat=%h want 0/%h", er, rd, ref_rd(16'h0012)); end
    tests++; if (lat !== TO + 1 || b.len !== TO) begin fails++; $display("FAIL ack_wins_timing: lat=%0d len=%0d want %0d/%0d", lat, b.len, TO + 1, TO); end
  endtask

  task automatic test_stall();
    int n; logic [7:0] d0; int bad; burst_t b;
    ack_wait = 0;
    @(negedge clk);
    wb.cmd_valid_i = 1'b1; wb.cmd_we_i = 1'b0; wb.cmd_adr_i = 16'h0012; wb.cmd_dat_i = 8'h00;
    n = 0;
    while (wb.cmd_ready_o !== 1'b1 && n < MAXW) begin @(negedge clk); n++; end
    @(negedge clk);
    // second command waits, valid held, while the first response is stalled
    wb.cmd_we_i = 1'b1; wb.cmd_adr_i = 16'h0055; wb.cmd_dat_i = 8'h3C;
    n = 0;
    while (wb.rsp_valid_o !== 1'b1 && n < MAXW) begin @(negedge clk); n++; end
    d0 = wb.rsp_dat_o;
    tests++; if (d0 !== ref_rd(16'h0012)) begin fails++; $display("FAIL stall_rdata: %h want %h", d0, ref_rd(16'h0012)); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb.cmd_ready_o !== 1'b0 || wb.rsp_valid_o !== 1'b1 || wb.rsp_dat_o !== d0 || wb.cyc_o !== 1'b0) bad++;
    end
    tests++; if (bad !== 0 || bq.size() !== 1) begin fails++; $display("FAIL stall_hold: %0d bad cycles, %0d bursts want 0/1", bad, bq.size()); end
    void'(pop_burst());
    wb.rsp_ready_i = 1'b1;
    @(negedge clk);
    wb.rsp_ready_i = 1'b0;
    tests++; if (wb.cmd_ready_o !== 1'b1) begin fails++; $display("FAIL stall_ready_after_take: %b want 1", wb.cmd_ready_o); end
    @(negedge clk);
    wb.cmd_valid_i = 1'b0;
    tests++; if (wb.cyc_o !== 1'b1) begin fails++; $display("FAIL stall_next_cmd: cyc_o=%b want 1", wb.cyc_o); end
    n = 0;
    while (wb.rsp_valid_o !== 1'b1 && n < MAXW) begin @(negedge clk); n++; end
    wb.rsp_ready_i = 1'b1;
    @(negedge clk);
    wb.rsp_ready_i = 1'b0;
    ref_mem[16'h0055] = 8'h3C;
    b = pop_burst();
    tests++; if (b.adr !== 16'h0055 || b.we !== 1'b1 || b.dat !== 8'h3C) begin fails++; $display("FAIL stall_second_bus: adr=%h we=%b dat=%h want 0055/1/3c", b.adr, b.we, b.dat); end
  endtask

  task automatic test_back_to_back();
    int n; burst_t b0, b1;
    ack_wait = 0;
    hs_q.delete();
    @(negedge clk);
    wb.rsp_ready_i = 1'b1;
    wb.cmd_valid_i = 1'b1; wb.cmd_we_i = 1'b1; wb.cmd_adr_i = 16'h0001; wb.cmd_dat_i = 8'h11;
    n = 0;
    while (wb.cmd_ready_o !== 1'b1 && n < MAXW) begin @(negedge clk); n++; end
    @(negedge clk);
    wb.cmd_adr_i = 16'h0002; wb.cmd_dat_i = 8'h22;
    n = 0;
    while (wb.cmd_ready_o !== 1'b1 && n < MAXW) begin @(negedge clk); n++; end
    @(negedge clk);
    wb.cmd_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    wb.rsp_ready_i = 1'b0;
    ref_mem[16'h0001] = 8'h11;
    ref_mem[16'h0002] = 8'h22;
    tests++; if (hs_q.size() !== 2) begin fails++; $display("FAIL b2b_handshakes: %0d want 2", hs_q.size()); end
    else begin
      tests++; if (hs_q[1] - hs_q[0] !== 3) begin fails++; $display("FAIL b2b_spacing: %0d cycles want 3", hs_q[1] - hs_q[0]); end
    end
    b0 = pop_burst();
    b1 = pop_burst();
    tests++; if (b0.adr !== 16'h0001 || b1.adr !== 16'h0002 || b0.len !== 1 || b1.len !== 1) begin fails++; $display("FAIL b2b_order: adr %h,%h len %0d,%0d want 0001,0002 len 1,1", b0.adr, b1.adr, b0.len, b1.len); end
  endtask

  task automatic test_random();
    logic [7:0] rd, xd; logic er, hd, we, to; int lat, dly, xl; logic [15:0] adr; logic [7:0] dat; burst_t b;
    for (int t = 0; t < 40; t++) begin
      to  = ($urandom_range(0, 7) == 0);
      ack_wait = to ? -1 : int'($urandom_range(0, 2));
      we  = 1'($urandom_range(0, 1));
      adr = 16'($urandom_range(0, 255));
      dat = 8'($urandom_range(0, 255));
      dly = int'($urandom_range(0, 3));
      if (to)      begin xd = 8'h00; xl = TO + 1; end
      else if (we) begin xd = 8'h00; xl = 2 + ack_wait; end
      else         begin xd = ref_rd(adr); xl = 2 + ack_wait; end
      do_cmd(we, adr, dat, dly, to, rd, er, lat, hd);
      if (we && !to) ref_mem[adr] = dat;
      b = pop_burst();
      tests++; if ({er, rd} !== {to, xd}) begin fails++; $display("FAIL rand_rsp[%0d]: err=%b dat=%h want %b/%h", t, er, rd, to, xd); end
      tests++; if (lat !== xl) begin fails++; $display("FAIL rand_latency[%0d]: %0d want %0d", t, lat, xl); end
      tests++; if (b.adr !== adr || b.we !== we || b.dat !== dat || b.len !== xl - 1) begin fails++; $display("FAIL rand_bus[%0d]: adr=%h we=%b dat=%h len=%0d want %h/%b/%h/%0d", t, b.adr, b.we, b.dat, b.len, adr, we, dat, xl - 1); end
      if (dly > 0) begin
        tests++; if (hd !== 1'b1) begin fails++; $display("FAIL rand_hold[%0d]: response not held for %0d cycles", t, dly); end
      end
    end
  endtask

  task automatic test_reset_mid_bus();
    int n, seen; logic [7:0] rd; logic er, hd; int lat;
    ack_wait = -1;
    @(negedge clk);
    wb.cmd_valid_i = 1'b1; wb.cmd_we_i = 1'b1; wb.cmd_adr_i = 16'h0077; wb.cmd_dat_i = 8'h99;
    n = 0;
    while (wb.cmd_ready_o !== 1'b1 && n < MAXW) begin @(negedge clk); n++; end
    @(negedge clk);
    wb.cmd_valid_i = 1'b0;
    tests++; if (wb.cyc_o !== 1'b1) begin fails++; $display("FAIL rst_bus_entry: cyc_o=%b want 1", wb.cyc_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if ({wb.cyc_o, wb.rsp_valid_o, wb.cmd_ready_o} !== 3'b001 || wb.adr_o !== 16'h0) begin fails++; $display("FAIL rst_mid_bus: cyc/rvalid/ready=%b adr=%h want 001/0000", {wb.cyc_o, wb.rsp_valid_o, wb.cmd_ready_o}, wb.adr_o); end
    seen = 0;
    repeat (8) begin @(negedge clk); if (wb.rsp_valid_o !== 1'b0) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rst_no_rsp: rsp_valid_o high %0d cycles want 0", seen); end
    bq.delete();
    ack_wait = 0;
    do_cmd(1'b0, 16'h0077, 8'h00, 0, 1'b0, rd, er, lat, hd);
    void'(pop_burst());
    tests++; if ({er, rd} !== {1'b0, ref_rd(16'h0077)}) begin fails++; $display("FAIL rst_aborted_write: err=%b dat=%h want 0/%h", er, rd, ref_rd(16'h0077)); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) slv_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read_registered();
    test_timeout();
    test_ack_at_timeout();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_bus();
    tests++; if (viol !== 0) begin fails++; $display("FAIL bus_protocol: %0d violations (unstable bus, stb/sel!=cyc, reassert after end) want 0", viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
